seq_judge: RTL and testbench

Parametrised sequence-approval FSM for the tt_um_erickespa top level. It watches a sample strobe and a pass/fail bit, and counts passing samples over a run of `N_STEPS` samples. It rejects early once approval becomes impossible, then presents a held verdict code until the hold time expires or the verdict is acknowledged. It generalises the fixed two-sample approve/reject chain with configurable run length, pass threshold, gap tolerance, verdict hold and saturating statistics counters.

---
 rtl/seq_judge_pkg.sv | 33 +++
 rtl/seq_judge_sat_counter.sv | 34 +++
 rtl/seq_judge.sv | 137 +++++++++++++
 tb/tb_seq_judge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_judge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_judge_pkg                                                        |
// | State encoding and verdict codes shared by the sequence judge.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seq_judge_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REJECT  = 2'd2,
      APPROVE = 2'd3
   } state_t;

   localparam logic [1:0] RES_IDLE    = 2'b00;
   localparam logic [1:0] RES_BUSY    = 2'b01;
   localparam logic [1:0] RES_REJECT  = 2'b10;
   localparam logic [1:0] RES_APPROVE = 2'b11;

   function automatic logic [1:0] result_of(input state_t s);
      logic [1:0] r;
      case (s)
         COLLECT: r = RES_BUSY;
         REJECT:  r = RES_REJECT;
         APPROVE: r = RES_APPROVE;
         default: r = RES_IDLE;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_judge_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Saturating up-counter with synchronous clear taking priority.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] c_max = {W{1'b1}};

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_max)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_judge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_judge                                                            |
// | Scores a run of sampled pass/fail bits and holds the verdict.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_judge
   import seq_judge_pkg::*;
#(
   parameter int N_STEPS     = 2,
   parameter int PASS_MIN    = 2,
   parameter int GAP_MAX     = 0,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sample_i,
   input  logic                           pass_i,
   input  logic                           ack_i,
   input  logic                           stats_clr_i,
   output logic [1:0]                     result_o,
   output logic                           busy_o,
   output logic [$clog2(N_STEPS+1)-1:0]   progress_o,
   output logic [CNT_W-1:0]               approve_cnt_o,
   output logic [CNT_W-1:0]               reject_cnt_o
);

   localparam int SW = $clog2(N_STEPS + 1);
   localparam int GW = $clog2(GAP_MAX + 2);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [SW-1:0] c_fail_limit = SW'(N_STEPS - PASS_MIN);
   localparam logic [SW-1:0] c_steps_full = SW'(N_STEPS);
   localparam logic [GW-1:0] c_gap_max    = GW'(GAP_MAX);
   localparam logic [HW-1:0] c_hold_load  = HW'(HOLD_CYCLES - 1);

   if ((N_STEPS < 1) || (PASS_MIN < 1) || (PASS_MIN > N_STEPS) ||
       (GAP_MAX < 0) || (HOLD_CYCLES < 1) || (CNT_W < 1)) begin : g_bad_params
      $error("seq_judge: illegal parameter combination");
   end

   state_t        r_state, w_state_nxt;
   logic [SW-1:0] r_steps, w_steps_nxt;
   logic [SW-1:0] r_fails, w_fails_nxt;
   logic [GW-1:0] r_gap,   w_gap_nxt;
   logic [HW-1:0] r_hold,  w_hold_nxt;
   logic          w_enter_approve;
   logic          w_enter_reject;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_steps <= '0;
         r_fails <= '0;
         r_gap   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_steps <= w_steps_nxt;
         r_fails <= w_fails_nxt;
         r_gap   <= w_gap_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // Pass count is implied: approval is reachable while fails stay within slack.
   always_comb begin
      w_state_nxt = r_state;
      w_steps_nxt = r_steps;
      w_fails_nxt = r_fails;
      w_gap_nxt   = r_gap;
      w_hold_nxt  = r_hold;
      case (r_state)
         IDLE: begin
            if (sample_i) begin
               w_state_nxt = COLLECT;
               w_steps_nxt = '0;
               w_fails_nxt = '0;
               w_gap_nxt   = '0;
            end
         end
         COLLECT: begin
            if (sample_i) begin
               w_steps_nxt = r_steps + SW'(1);
               w_fails_nxt = r_fails + SW'(!pass_i);
               w_gap_nxt   = '0;
               if (w_fails_nxt > c_fail_limit) begin
                  w_state_nxt = REJECT;
                  w_hold_nxt  = c_hold_load;
               end else if (w_steps_nxt == c_steps_full) begin
                  w_state_nxt = APPROVE;
                  w_hold_nxt  = c_hold_load;
               end
            end else begin
               w_gap_nxt = r_gap + GW'(1);
               if (w_gap_nxt > c_gap_max) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         REJECT, APPROVE: begin
            if ((r_hold == '0) || ack_i) begin
               w_state_nxt = IDLE;
            end else begin
               w_hold_nxt = r_hold - HW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_enter_approve = (r_state == COLLECT) && (w_state_nxt == APPROVE);
   assign w_enter_reject  = (r_state == COLLECT) && (w_state_nxt == REJECT);

   sat_counter #(.W(CNT_W)) u_approve_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_enter_approve),
      .clr   (stats_clr_i),
      .count (approve_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_reject_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_enter_reject),
      .clr   (stats_clr_i),
      .count (reject_cnt_o)
   );

   assign result_o   = result_of(r_state);
   assign busy_o     = (r_state != IDLE);
   assign progress_o = (r_state == IDLE) ? '0 : r_steps;

endmodule
`default_nettype wire

// File: tb/tb_seq_judge.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_seq_judge                                                         |
// | Two configurations of seq_judge checked against a run-level model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seq_judge;

   localparam int A_N = 2, A_P = 2, A_G = 0, A_H = 4, A_CW = 8;
   localparam int B_N = 5, B_P = 3, B_G = 2, B_H = 3, B_CW = 2;

   localparam int PH_IDLE = 0, PH_RUN = 1, PH_REJ = 2, PH_APP = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic s0 = 1'b0, p0 = 1'b0, a0 = 1'b0, c0 = 1'b0;
   logic s1 = 1'b0, p1 = 1'b0, a1 = 1'b0, c1 = 1'b0;

   logic [1:0]                   res0, res1;
   logic                         busy0, busy1;
   logic [$clog2(A_N+1)-1:0]     prog0;
   logic [$clog2(B_N+1)-1:0]     prog1;
   logic [A_CW-1:0]              acnt0, rcnt0;
   logic [B_CW-1:0]              acnt1, rcnt1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_judge #(.N_STEPS(A_N), .PASS_MIN(A_P), .GAP_MAX(A_G), .HOLD_CYCLES(A_H), .CNT_W(A_CW)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sample_i(s0), .pass_i(p0), .ack_i(a0), .stats_clr_i(c0),
      .result_o(res0), .busy_o(busy0), .progress_o(prog0),
      .approve_cnt_o(acnt0), .reject_cnt_o(rcnt0));

   seq_judge #(.N_STEPS(B_N), .PASS_MIN(B_P), .GAP_MAX(B_G), .HOLD_CYCLES(B_H), .CNT_W(B_CW)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sample_i(s1), .pass_i(p1), .ack_i(a1), .stats_clr_i(c1),
      .result_o(res1), .busy_o(busy1), .progress_o(prog1),
      .approve_cnt_o(acnt1), .reject_cnt_o(rcnt1));

   // Run-level view: where we are, samples/fails so far, idle streak,
   // verdict cycles still to show, and the two tallies.
   typedef struct packed {
      int phase;
      int steps;
      int fails;
      int gap;
      int left;
      int acnt;
      int rcnt;
   } mdl_t;

   mdl_t m0 = '{default: 0};
   mdl_t m1 = '{default: 0};

   function automatic mdl_t step(input mdl_t m, input int n, input int pmin, input int gmax,
                                 input int hold, input int cw,
                                 input logic s, input logic pa, input logic a, input logic c);
      mdl_t r;
      bit   won, lost;
      int   cmax;
      r    = m;
      won  = 0;
      lost = 0;
      cmax = (1 << cw) - 1;
      if (m.phase == PH_IDLE) begin
         if (s) begin
            r.phase = PH_RUN;
            r.steps = 0;
            r.fails = 0;
            r.gap   = 0;
         end
      end else if (m.phase == PH_RUN) begin
         if (s) begin
            r.steps = m.steps + 1;
            r.fails = m.fails + (pa ? 0 : 1);
            r.gap   = 0;
            if (r.fails > n - pmin) begin
               lost = 1;
            end else if (r.steps == n) begin
               won = 1;
            end
         end else begin
            r.gap = m.gap + 1;
            if (r.gap > gmax) r.phase = PH_IDLE;
         end
         if (lost) begin r.phase = PH_REJ; r.left = hold; end
         if (won)  begin r.phase = PH_APP; r.left = hold; end
      end else begin
         r.left = m.left - 1;
         if (r.left == 0 || a) r.phase = PH_IDLE;
      end
      if (c) begin
         r.acnt = 0;
         r.rcnt = 0;
      end else begin
         if (won  && r.acnt < cmax) r.acnt = r.acnt + 1;
         if (lost && r.rcnt < cmax) r.rcnt = r.rcnt + 1;
      end
      return r;
   endfunction

   function automatic int exp_res(input mdl_t m);
      case (m.phase)
         PH_RUN:  return 1;
         PH_REJ:  return 2;
         PH_APP:  return 3;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= '{default: 0};
         m1 <= '{default: 0};
      end else begin
         m0 <= step(m0, A_N, A_P, A_G, A_H, A_CW, s0, p0, a0, c0);
         m1 <= step(m1, B_N, B_P, B_G, B_H, B_CW, s1, p1, a1, c1);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("d0_result",   int'(res0),  exp_res(m0));
      chk("d0_busy",     int'(busy0), (m0.phase != PH_IDLE) ? 1 : 0);
      chk("d0_progress", int'(prog0), (m0.phase == PH_IDLE) ? 0 : m0.steps);
      chk("d0_approve",  int'(acnt0), m0.acnt);
      chk("d0_reject",   int'(rcnt0), m0.rcnt);
      chk("d1_result",   int'(res1),  exp_res(m1));
      chk("d1_busy",     int'(busy1), (m1.phase != PH_IDLE) ? 1 : 0);
      chk("d1_progress", int'(prog1), (m1.phase == PH_IDLE) ? 0 : m1.steps);
      chk("d1_approve",  int'(acnt1), m1.acnt);
      chk("d1_reject",   int'(rcnt1), m1.rcnt);
   end

   task automatic drv0(input logic s, input logic p, input logic a, input logic c);
      s0 = s; p0 = p; a0 = a; c0 = c;
      @(posedge clk);
      #1;
      s0 = 1'b0; p0 = 1'b0; a0 = 1'b0; c0 = 1'b0;
   endtask

   task automatic drv1(input logic s, input logic p, input logic a, input logic c);
      s1 = s; p1 = p; a1 = a; c1 = c;
      @(posedge clk);
      #1;
      s1 = 1'b0; p1 = 1'b0; a1 = 1'b0; c1 = 1'b0;
   endtask

   task automatic approve_run1(input logic clr_last);
      drv1(1, 0, 0, 0);
      repeat (B_N - 1) drv1(1, 1, 0, 0);
      drv1(1, 1, 0, clr_last);
      repeat (B_H) drv1(0, 0, 0, 0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_res0", int'(res0), 0);
      chk("rst_busy0", int'(busy0), 0);
      chk("rst_acnt1", int'(acnt1), 0);

      // default config: start + two passes -> approve, held 4 cycles
      drv0(1, 0, 0, 0); chk("a1_res_start", int'(res0), 1); chk("a1_prog_start", int'(prog0), 0);
      drv0(1, 1, 0, 0); chk("a1_res_s1", int'(res0), 1); chk("a1_prog_s1", int'(prog0), 1);
      drv0(1, 1, 0, 0); chk("a1_res_s2", int'(res0), 3); chk("a1_prog_s2", int'(prog0), 2);
      chk("a1_acnt", int'(acnt0), 1);
      repeat (3) begin drv0(0, 0, 0, 0); chk("a1_hold", int'(res0), 3); end
      drv0(0, 0, 0, 0); chk("a1_exit", int'(res0), 0); chk("a1_prog_idle", int'(prog0), 0);

      // default config: first failing sample rejects
      drv0(1, 0, 0, 0);
      drv0(1, 0, 0, 0); chk("a2_res", int'(res0), 2); chk("a2_rcnt", int'(rcnt0), 1);
      chk("a2_prog", int'(prog0), 1);
      repeat (3) begin drv0(0, 0, 0, 0); chk("a2_hold", int'(res0), 2); end
      drv0(0, 0, 0, 0); chk("a2_exit", int'(res0), 0);

      // ack in verdict cycle 2; sample in the release cycle is dropped
      drv0(1, 0, 0, 0); drv0(1, 1, 0, 0); drv0(1, 1, 0, 0);
      drv0(0, 0, 0, 0); chk("a3_cyc2", int'(res0), 3);
      drv0(1, 0, 1, 0); chk("a3_ack_exit", int'(res0), 0); chk("a3_acnt", int'(acnt0), 2);
      drv0(0, 0, 1, 0); chk("a3_ack_idle", int'(res0), 0);

      // N=5, PASS_MIN=3: early reject on fourth sample
      drv1(1, 0, 0, 0);
      drv1(1, 1, 0, 0); drv1(1, 0, 0, 0); drv1(1, 0, 0, 0);
      chk("b1_res_s3", int'(res1), 1); chk("b1_prog_s3", int'(prog1), 3);
      drv1(1, 0, 0, 0); chk("b1_res", int'(res1), 2); chk("b1_prog", int'(prog1), 4);
      chk("b1_rcnt", int'(rcnt1), 1);
      repeat (2) begin drv1(0, 0, 0, 0); chk("b1_hold_prog", int'(prog1), 4); end
      drv1(0, 0, 0, 0); chk("b1_exit", int'(res1), 0);

      // 1,0,1,1,0 approves with full progress
      drv1(1, 0, 0, 0);
      drv1(1, 1, 0, 0); drv1(1, 0, 0, 0); drv1(1, 1, 0, 0); drv1(1, 1, 0, 0);
      drv1(1, 0, 0, 0); chk("b2_res", int'(res1), 3); chk("b2_prog", int'(prog1), 5);
      chk("b2_acnt", int'(acnt1), 1);
      repeat (B_H) drv1(0, 0, 0, 0);
      chk("b2_exit", int'(res1), 0);

      // gap of 2 tolerated
      drv1(1, 0, 0, 0); drv1(1, 1, 0, 0);
      drv1(0, 0, 0, 0); drv1(0, 0, 0, 0);
      chk("b3_gap_res", int'(res1), 1); chk("b3_gap_prog", int'(prog1), 1);
      repeat (B_N - 1) drv1(1, 1, 0, 0);
      chk("b3_res", int'(res1), 3); chk("b3_acnt", int'(acnt1), 2);
      repeat (B_H) drv1(0, 0, 0, 0);

      // gap of 3 abandons the run without a verdict
      drv1(1, 0, 0, 0); drv1(1, 1, 0, 0);
      drv1(0, 0, 0, 0); drv1(0, 0, 0, 0); chk("b4_still", int'(res1), 1);
      drv1(0, 0, 0, 0); chk("b4_abort", int'(res1), 0);
      chk("b4_acnt", int'(acnt1), 2); chk("b4_rcnt", int'(rcnt1), 1);

      // saturation at 3, then clear wins over a coinciding increment
      drv1(0, 0, 0, 1); chk("b5_clr", int'(acnt1), 0);
      repeat (5) approve_run1(1'b0);
      chk("b5_sat", int'(acnt1), 3);
      approve_run1(1'b1);
      chk("b5_clr_wins", int'(acnt1), 0);

      // async reset in the middle of a run
      drv0(1, 0, 0, 0); drv0(1, 1, 0, 0); chk("r_pre", int'(res0), 1);
      rst_n = 1'b0;
      #1;
      chk("r_res0", int'(res0), 0); chk("r_busy0", int'(busy0), 0);
      chk("r_prog0", int'(prog0), 0); chk("r_acnt0", int'(acnt0), 0);
      chk("r_rcnt0", int'(rcnt0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      repeat (3000) begin
         s0 = ($urandom_range(0, 3) != 0);
         p0 = ($urandom_range(0, 3) != 0);
         a0 = ($urandom_range(0, 15) == 0);
         c0 = ($urandom_range(0, 63) == 0);
         s1 = ($urandom_range(0, 2) != 0);
         p1 = ($urandom_range(0, 4) != 0);
         a1 = ($urandom_range(0, 11) == 0);
         c1 = ($urandom_range(0, 63) == 0);
         @(posedge clk);
         #1;
      end
      s0 = 1'b0; p0 = 1'b0; a0 = 1'b0; c0 = 1'b0;
      s1 = 1'b0; p1 = 1'b0; a1 = 1'b0; c1 = 1'b0;
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
